flop_en_rst_clr: RTL and testbench
==================================

Name: flop_en_rst_clr

Overview:
Generic parameterized D flip-flop register with synchronous reset, synchronous clear and load enable. It is the basic storage element for pipeline registers such as ID/EX. Those registers bit-cast packed control/data structs to flat vectors and use clr to inject bubbles on flush. Reset and clear load independently parameterized constants.

Parameters:
WIDTH, 32, register width in bits; must be >= 1 (elaboration-time check, fatal if violated).
RESET_VAL, '0, WIDTH-bit value loaded while rst is high.
CLEAR_VAL, '0, WIDTH-bit value loaded while clr is high and rst is low.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  reset, synchronous, active-high; loads RESET_VAL.
en  input  1  load enable, active-high; captures d.
clr  input  1  synchronous clear, active-high; loads CLEAR_VAL (flush/bubble).
d  input  WIDTH  data input.
q  output  WIDTH  registered output.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. No asynchronous paths.
- q is driven directly from the flop; no combinational path from any input to q.
- Rising-edge update, in strict priority order:
  - rst=1: q <= RESET_VAL, regardless of clr, en and d.
  - else clr=1: q <= CLEAR_VAL, regardless of en (a flush overrides a stall).
  - else en=1: q <= d.
  - else: q holds its value.
- Latency: one cycle from d to q when en=1.
- Reset value of q is RESET_VAL, visible after the first rising edge with rst=1. Before the first reset, q is unknown (X in simulation).
- Reset mid-operation: takes effect on the next edge. Loaded data and any pending clear are discarded.
- Simultaneous events:
  - rst+clr+en: RESET_VAL.
  - clr+en: CLEAR_VAL.
  - clr with en=0: CLEAR_VAL.
- RESET_VAL and CLEAR_VAL are full WIDTH-bit constants, with no sign extension or truncation semantics beyond standard width matching. They may differ.
- X on en or clr while rst=1 does not affect q.
- Fully synthesizable; maps to WIDTH flops plus a priority mux.

Test Plan:
- WIDTH=8, RESET_VAL=8'hA5, CLEAR_VAL=8'h3C. Assert rst one cycle with en=1, clr=1, d=8'hFF -> q=8'hA5 after the edge.
- rst=0, clr=0, en=1, d=8'h11 then 8'h22 on consecutive edges -> q=8'h11 then 8'h22, each one cycle after d.
- en=0, d toggles 8'h77 and 8'h88 for 3 cycles -> q holds 8'h22.
- clr=1 with en=0, d=8'h55 -> q=8'h3C. Next edge clr=0, en=1, d=8'h55 -> q=8'h55.
- clr=1 with en=1, d=8'h99 -> q=8'h3C, not 8'h99. Then rst=1 with clr=1 -> q=8'hA5.
- Default parameters (WIDTH=32, values '0): load 32'hDEADBEEF, then clr=1 -> q=32'h0. Then load 32'h12345678 and rst=1 -> q=32'h0.

Source files
------------

// File: rtl/flop_en_rst_clr.sv
// ============================================================================
//  Module      : flop_en_rst_clr
//  Description : Parameterized D register with synchronous reset, synchronous
//                clear and load enable (priority rst > clr > en > hold).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flop_en_rst_clr #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter logic [WIDTH-1:0]   CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (WIDTH < 1) begin : g_width_check
            $fatal(1, "flop_en_rst_clr: WIDTH must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Flush wins over stall so a bubble is injected even when the stage is held.
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = CLEAR_VAL;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

`default_nettype wire

// File: tb/tb_flop_en_rst_clr.sv
// ============================================================================
//  Module      : tb_flop_en_rst_clr
//  Description : Scoreboard bench for flop_en_rst_clr (8-bit and default cfg).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flop_en_rst_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8  = 1'b1;
    logic        en8   = 1'b0;
    logic        clr8  = 1'b0;
    logic [7:0]  d8    = 8'h00;
    logic [7:0]  q8;

    logic        rst32 = 1'b1;
    logic        en32  = 1'b0;
    logic        clr32 = 1'b0;
    logic [31:0] d32   = 32'h0;
    logic [31:0] q32;

    flop_en_rst_clr #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5),
        .CLEAR_VAL (8'h3C)
    ) u_dut8 (
        .clk (clk),
        .rst (rst8),
        .en  (en8),
        .clr (clr8),
        .d   (d8),
        .q   (q8)
    );

    flop_en_rst_clr u_dut32 (
        .clk (clk),
        .rst (rst32),
        .en  (en32),
        .clr (clr32),
        .d   (d32),
        .q   (q32)
    );

    typedef struct {
        bit          wide;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Inputs change on the falling edge; expectation applies to the next rising edge.
    task automatic drive8(input logic r, input logic e, input logic c,
                          input logic [7:0] dv, input logic [7:0] ex,
                          input string nm);
        exp_t item;
        @(negedge clk);
        rst8 = r; en8 = e; clr8 = c; d8 = dv;
        item.wide = 1'b0;
        item.exp  = {24'h0, ex};
        item.name = nm;
        sb.push_back(item);
    endtask

    task automatic drive32(input logic r, input logic e, input logic c,
                           input logic [31:0] dv, input logic [31:0] ex,
                           input string nm);
        exp_t item;
        @(negedge clk);
        rst32 = r; en32 = e; clr32 = c; d32 = dv;
        item.wide = 1'b1;
        item.exp  = ex;
        item.name = nm;
        sb.push_back(item);
    endtask

    // Monitor: one expectation retired per rising edge, sampled 1 time unit later.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = e.wide ? q32 : {24'h0, q8};
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        // 8-bit configuration
        drive8(1'b1, 1'b1, 1'b1, 8'hFF, 8'hA5, "rst_all_high");
        drive8(1'b1, 1'bx, 1'bx, 8'h00, 8'hA5, "rst_x_ctrl");
        drive8(1'b0, 1'b1, 1'b0, 8'h11, 8'h11, "load_11");
        drive8(1'b0, 1'b1, 1'b0, 8'h22, 8'h22, "load_22");
        drive8(1'b0, 1'b0, 1'b0, 8'h77, 8'h22, "hold_1");
        drive8(1'b0, 1'b0, 1'b0, 8'h88, 8'h22, "hold_2");
        drive8(1'b0, 1'b0, 1'b0, 8'h77, 8'h22, "hold_3");
        drive8(1'b0, 1'b0, 1'b1, 8'h55, 8'h3C, "clr_no_en");
        drive8(1'b0, 1'b1, 1'b0, 8'h55, 8'h55, "load_55");
        drive8(1'b0, 1'b1, 1'b1, 8'h99, 8'h3C, "clr_over_en");
        drive8(1'b0, 1'b1, 1'b0, 8'h66, 8'h66, "load_66");
        drive8(1'b1, 1'b0, 1'b1, 8'h00, 8'hA5, "rst_over_clr");
        drive8(1'b0, 1'b0, 1'b0, 8'hC3, 8'hA5, "hold_after_rst");

        // Default configuration: WIDTH=32, both constants zero
        drive32(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, "w32_reset");
        drive32(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "w32_load_deadbeef");
        drive32(1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0000_0000, "w32_clr");
        drive32(1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, "w32_load_12345678");
        drive32(1'b0, 1'b0, 1'b0, 32'h0BAD_0BAD, 32'h1234_5678, "w32_hold");
        drive32(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, "w32_rst_over_en");

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
